// File: rtl/mem_pkg.sv
// Shared types and defaults for the memory responder slice.
package mem_pkg;
  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Index width for a DEPTH-entry array; a single-entry array still needs one bit.
  function automatic int idx_w(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction
endpackage

// File: rtl/mem_array.sv
// Single-port synchronous storage with registered read data; no reset on contents.
module mem_array #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 64,
  parameter int AW     = 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end
endmodule

// File: rtl/mem_responder.sv
// Request/response memory slave: accepts one request, waits WAIT_CYCLES, then
// holds a response until the initiator takes it.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic              busy
);
  localparam int              AW      = idx_w(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  state_t            state;
  logic [7:0]        cnt;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rd_ok;
  logic [DATA_W-1:0] rdata;

  logic              accept, enter_resp;
  logic              cur_we, cur_oor;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;

  // With zero wait states the array is accessed on the acceptance edge itself,
  // so the live request feeds it in IDLE and the latches feed it afterwards.
  assign cur_we     = (state == IDLE) ? req_we    : we_q;
  assign cur_addr   = (state == IDLE) ? req_addr  : addr_q;
  assign cur_wdata  = (state == IDLE) ? req_wdata : wdata_q;
  assign cur_oor    = {1'b0, cur_addr} >= DEPTH_L;
  assign accept     = req_valid && req_ready && (state == IDLE);
  assign enter_resp = (accept && (WAIT_CYCLES == 0)) || ((state == WAIT) && (cnt == 8'd1));

  mem_array #(.DEPTH(DEPTH), .DATA_W(DATA_W), .AW(AW)) u_mem (
    .clk   (clk),
    .en    (enter_resp && !cur_oor),
    .we    (cur_we),
    .addr  (cur_addr[AW-1:0]),
    .wdata (cur_wdata),
    .rdata (rdata)
  );

  assign resp_data = rd_ok ? rdata : '0;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      rd_ok      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      if (enter_resp) begin
        state      <= RESP;
        resp_valid <= 1'b1;
        resp_err   <= cur_oor;
        rd_ok      <= !cur_we && !cur_oor;
      end
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            req_ready <= 1'b0;
            we_q      <= req_we;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            if (WAIT_CYCLES != 0) begin
              state <= WAIT;
              cnt   <= 8'(WAIT_CYCLES);
            end
          end
        end
        WAIT: cnt <= cnt - 8'd1;
        RESP: begin
          // Returning to IDLE with req_ready raised only now guarantees one idle cycle.
          if (resp_ready) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            rd_ok      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// Bench: two responders (2 wait states / 0 wait states) against a timing model.
module tb_mem_responder;
  logic        clk;
  logic        rst;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_we     [2];
  logic [15:0] req_addr   [2];
  logic [63:0] req_wdata  [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [63:0] resp_data  [2];
  logic        resp_err   [2];
  logic        busy       [2];

  int nchk = 0;
  int nfail = 0;

  mem_responder #(.ADDR_W(16), .DATA_W(64), .DEPTH(256), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_data(resp_data[0]),
    .resp_err(resp_err[0]), .busy(busy[0]));

  mem_responder #(.ADDR_W(16), .DATA_W(64), .DEPTH(256), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_data(resp_data[1]),
    .resp_err(resp_err[1]), .busy(busy[1]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int wc(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  // Model: a transaction accepted at edge acc responds from edge acc+W until taken.
  int          cyc = 0;
  bit          pend [2];
  bit          rdy  [2];
  int          acc  [2];
  bit          mwe  [2];
  int          maddr[2];
  logic [63:0] mwd  [2];
  logic [63:0] mm   [2][256];
  bit          mv   [2][256];
  bit          started = 0;

  initial begin
    for (int i = 0; i < 2; i++) begin
      pend[i] = 0; rdy[i] = 0; acc[i] = 0; mwe[i] = 0; maddr[i] = 0; mwd[i] = '0;
      for (int a = 0; a < 256; a++) mv[i][a] = 0;
    end
  end

  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        pend[i] = 0;
        rdy[i]  = 0;
      end else begin
        if (pend[i]) begin
          if (cyc - 1 >= acc[i] + wc(i) && resp_ready[i]) begin
            pend[i] = 0;
            rdy[i]  = 1;
          end
        end else if (rdy[i]) begin
          if (req_valid[i]) begin
            pend[i]  = 1;
            rdy[i]   = 0;
            acc[i]   = cyc;
            mwe[i]   = req_we[i];
            maddr[i] = int'(req_addr[i]);
            mwd[i]   = req_wdata[i];
          end
        end else begin
          rdy[i] = 1;
        end
        if (pend[i] && cyc == acc[i] + wc(i) && mwe[i] && maddr[i] < 256) begin
          mm[i][maddr[i]] = mwd[i];
          mv[i][maddr[i]] = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        bit          e_rdy, e_busy, e_v, e_err, dchk;
        logic [63:0] e_data;
        e_rdy  = !rst && rdy[i];
        e_busy = !rst && pend[i];
        e_v    = e_busy && (cyc >= acc[i] + wc(i));
        e_err  = e_v && (maddr[i] >= 256);
        e_data = '0;
        dchk   = 1;
        if (e_v && !mwe[i] && maddr[i] < 256) begin
          if (mv[i][maddr[i]]) e_data = mm[i][maddr[i]];
          else dchk = 0;
        end
        chk($sformatf("m%0d_req_ready", i), {63'd0, req_ready[i]}, {63'd0, e_rdy});
        chk($sformatf("m%0d_busy", i), {63'd0, busy[i]}, {63'd0, e_busy});
        chk($sformatf("m%0d_resp_valid", i), {63'd0, resp_valid[i]}, {63'd0, e_v});
        chk($sformatf("m%0d_resp_err", i), {63'd0, resp_err[i]}, {63'd0, e_err});
        if (dchk) chk($sformatf("m%0d_resp_data", i), resp_data[i], e_data);
      end
    end
  end

  task automatic txn(input int i, input bit we, input logic [15:0] a, input logic [63:0] d,
                     input bit rr, output int lat, output logic [63:0] data, output logic err);
    int n;
    @(negedge clk); #1;
    n = 0;
    while (!req_ready[i] && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    if (!req_ready[i]) chk("ready_timeout", {63'd0, req_ready[i]}, 64'd1);
    req_valid[i] = 1'b1; req_we[i] = we; req_addr[i] = a; req_wdata[i] = d; resp_ready[i] = rr;
    @(posedge clk); #1;
    // Scramble the request fields; the responder must use its latched copy.
    req_valid[i] = 1'b0; req_we[i] = ~we; req_addr[i] = ~a; req_wdata[i] = ~d;
    lat = 1;
    @(negedge clk);
    while (!resp_valid[i] && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    data = resp_data[i];
    err  = resp_err[i];
  endtask

  int          lat;
  logic [63:0] rd;
  logic        er;

  initial begin
    #150000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 0; req_we[i] = 0; req_addr[i] = '0; req_wdata[i] = '0; resp_ready[i] = 1;
    end
    #1 rst = 1'b1;
    started = 1;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {63'd0, req_ready[0]}, 64'd0);
    chk("rst_resp_valid", {63'd0, resp_valid[0]}, 64'd0);
    chk("rst_busy", {63'd0, busy[0]}, 64'd0);
    chk("rst_resp_data", resp_data[0], 64'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", {63'd0, req_ready[0]}, 64'd1);

    // Preload
    txn(0, 1, 16'h0000, 64'hAA, 1, lat, rd, er);
    txn(0, 1, 16'h0003, 64'h11, 1, lat, rd, er);

    // Write then read, 2 wait states
    txn(0, 1, 16'h0005, 64'h0123456789ABCDEF, 1, lat, rd, er);
    chk("w5_latency", 64'(lat), 64'd3);
    chk("w5_data", rd, 64'd0);
    chk("w5_err", {63'd0, er}, 64'd0);
    txn(0, 0, 16'h0005, 64'h0, 1, lat, rd, er);
    chk("r5_latency", 64'(lat), 64'd3);
    chk("r5_data", rd, 64'h0123456789ABCDEF);

    // Zero wait states
    txn(1, 1, 16'h0005, 64'hDEADBEEF00000001, 1, lat, rd, er);
    chk("z_w5_latency", 64'(lat), 64'd1);
    txn(1, 0, 16'h0005, 64'h0, 1, lat, rd, er);
    chk("z_r5_latency", 64'(lat), 64'd1);
    chk("z_r5_data", rd, 64'hDEADBEEF00000001);

    // Address range boundaries
    txn(0, 1, 16'h0100, 64'hFF, 1, lat, rd, er);
    chk("oor_w_err", {63'd0, er}, 64'd1);
    chk("oor_w_data", rd, 64'd0);
    txn(0, 0, 16'h0000, 64'h0, 1, lat, rd, er);
    chk("r0_data", rd, 64'hAA);
    chk("r0_err", {63'd0, er}, 64'd0);
    txn(0, 1, 16'h00FF, 64'h5A5A, 1, lat, rd, er);
    chk("w255_err", {63'd0, er}, 64'd0);
    txn(0, 0, 16'h00FF, 64'h0, 1, lat, rd, er);
    chk("r255_data", rd, 64'h5A5A);
    txn(0, 0, 16'hFFFF, 64'h0, 1, lat, rd, er);
    chk("oor_r_err", {63'd0, er}, 64'd1);
    chk("oor_r_data", rd, 64'd0);

    // Back-pressure in RESP
    txn(0, 0, 16'h0005, 64'h0, 0, lat, rd, er);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 16'(k); req_wdata[0] = 64'(k);
      @(negedge clk);
      chk("hold_valid", {63'd0, resp_valid[0]}, 64'd1);
      chk("hold_data", resp_data[0], 64'h0123456789ABCDEF);
      chk("hold_err", {63'd0, resp_err[0]}, 64'd0);
      chk("hold_req_ready", {63'd0, req_ready[0]}, 64'd0);
      #1 req_valid[0] = 1'b0;
    end
    resp_ready[0] = 1'b1;
    @(posedge clk); #1;
    chk("taken_valid", {63'd0, resp_valid[0]}, 64'd0);
    chk("taken_data", resp_data[0], 64'd0);
    chk("taken_ready_reg", {63'd0, req_ready[0]}, 64'd1);

    // Reset during WAIT of a write
    @(negedge clk); #1;
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 16'h0003; req_wdata[0] = 64'h77;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("wait_busy", {63'd0, busy[0]}, 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("arst_busy", {63'd0, busy[0]}, 64'd0);
    chk("arst_req_ready", {63'd0, req_ready[0]}, 64'd0);
    chk("arst_resp_valid", {63'd0, resp_valid[0]}, 64'd0);
    chk("arst_resp_err", {63'd0, resp_err[0]}, 64'd0);
    chk("arst_resp_data", resp_data[0], 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk); #1 rst = 1'b0;
    txn(0, 0, 16'h0003, 64'h0, 1, lat, rd, er);
    chk("r3_after_rst", rd, 64'h11);

    // Back-to-back with req_valid held high
    begin
      int a1, h1, a2;
      a1 = -1; h1 = -1; a2 = -1;
      @(negedge clk); #1;
      req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 16'h0005; resp_ready[0] = 1'b1;
      for (int k = 0; k < 16; k++) begin
        @(negedge clk);
        if (req_ready[0]) begin
          if (a1 < 0) a1 = k;
          else if (h1 >= 0 && a2 < 0) a2 = k;
        end
        if (resp_valid[0] && h1 < 0 && a1 >= 0) begin
          h1 = k;
          chk("b2b_ready_at_return", {63'd0, req_ready[0]}, 64'd0);
        end
      end
      #1 req_valid[0] = 1'b0;
      chk("b2b_first_accept", {63'd0, a1 >= 0}, 64'd1);
      chk("b2b_second_accept", {63'd0, a2 >= 0}, 64'd1);
      chk("b2b_gap_ge1", {63'd0, (a2 - h1) >= 1}, 64'd1);
    end
    repeat (8) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, request address width.
REQ-002 SHALL have parameter DATA_W, default 64, data word width.
REQ-003 SHALL have parameter DEPTH, default 256, number of storage words; legal range 1..2^ADDR_W.
REQ-004 SHALL have parameter WAIT_CYCLES, default 2, wait states inserted before each response; legal range 0..255.
REQ-005 SHALL have port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port req_valid, input, 1, initiator presents a request.
REQ-008 SHALL have port req_ready, output, 1, responder accepts a request this cycle.
REQ-009 SHALL have port req_we, input, 1, 1 = write, 0 = read.
REQ-010 SHALL have port req_addr, input, ADDR_W, word address.
REQ-011 SHALL have port req_wdata, input, DATA_W, write data.
REQ-012 SHALL have port resp_valid, output, 1, response present.
REQ-013 SHALL have port resp_ready, input, 1, initiator takes the response.
REQ-014 SHALL have port resp_data, output, DATA_W, read data; 0 for writes and errors.
REQ-015 SHALL have port resp_err, output, 1, address out of range.
REQ-016 SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-017 SHALL implement a 3-state FSM: IDLE, WAIT, RESP.
REQ-018 SHALL drive req_ready=1 only in IDLE; a request is accepted on a clk edge with req_valid && req_ready.
REQ-019 SHALL latch req_we, req_addr and req_wdata on acceptance; later changes to these inputs are ignored until the next acceptance.
REQ-020 SHALL, on acceptance, go to RESP when WAIT_CYCLES=0; otherwise go to WAIT with the wait counter loaded to WAIT_CYCLES.
REQ-021 SHALL, in WAIT, decrement the counter each cycle and go to RESP on the edge where the counter equals 1.
REQ-022 SHALL assert resp_valid exactly 1+WAIT_CYCLES cycles after the acceptance edge.
REQ-023 SHALL treat latched addr >= DEPTH as an error: resp_err=1, resp_data=0, storage unmodified.
REQ-024 SHALL, for an in-range read, register storage[addr] into resp_data on the edge entering RESP.
REQ-025 SHALL, for an in-range write, update storage[addr] on the edge entering RESP and drive resp_data=0, resp_err=0.
REQ-026 SHALL hold resp_valid, resp_data and resp_err stable in RESP until resp_ready=1.
REQ-027 SHALL, on the edge with resp_valid && resp_ready, return to IDLE and drive resp_valid=0, resp_err=0, resp_data=0; it SHALL NOT accept a new request on that edge (minimum 1 idle cycle between transactions).
REQ-028 SHALL ignore resp_ready outside RESP and req_valid outside IDLE.
REQ-029 SHALL, for a write followed by a read of the same address, return the written data.
REQ-030 SHALL have a fixed read result for uninitialised storage words: X in simulation; the bench SHALL NOT check it.

Reset
REQ-031 SHALL, while rst=1, force state=IDLE, wait counter=0, resp_valid=0, resp_err=0, resp_data=0, busy=0, and req_ready=0 (req_ready=1 from the first edge after rst falls).
REQ-032 SHALL drop any accepted but not yet completed transaction on reset; a write whose RESP-entry edge has not occurred SHALL NOT modify storage.
REQ-033 SHALL NOT clear storage contents on reset.

Structure
REQ-034 SHALL place the FSM state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2) and default ADDR_W/DATA_W constants in shared package mem_pkg.
REQ-035 SHALL instantiate one sub-module, mem_array: a DEPTH x DATA_W single-port synchronous storage with we, addr, wdata and registered rdata, without reset.
REQ-036 SHALL keep the FSM, wait counter, request latches and error check in mem_responder.

Verification
REQ-037 SHALL cover: WAIT_CYCLES=2, write addr 0x0005 data 0x0123456789ABCDEF, resp_ready=1 -> resp_valid at acceptance+3, resp_data=0, resp_err=0; then read 0x0005 -> resp_data=0x0123456789ABCDEF at acceptance+3.
REQ-038 SHALL cover: WAIT_CYCLES=0, read 0x0005 -> resp_valid on cycle acceptance+1.
REQ-039 SHALL cover: DEPTH=256, write addr 0x0100 data 0xFF -> resp_err=1, resp_data=0; then read 0x0000 (pre-written 0xAA) -> resp_data=0xAA, resp_err=0.
REQ-040 SHALL cover: resp_ready held 0 for 5 cycles in RESP -> resp_valid, resp_data and resp_err stable; req_ready=0; req_valid pulses ignored.
REQ-041 SHALL cover: rst asserted in WAIT during a write of 0x77 to addr 3 (old value 0x11) -> all outputs reset immediately; subsequent read of addr 3 returns 0x11.
REQ-042 SHALL cover: back-to-back req_valid held high -> req_ready low on the handshake-return edge; second acceptance no earlier than 1 cycle after return to IDLE.
